// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, block geometry and the IV.
package sha256_pkg;

  localparam int unsigned NUM_ROUNDS_DEFAULT = 64;
  localparam int unsigned BLOCK_W            = 512;
  localparam int unsigned ROUND_W            = 6;

  // H0..H7, H0 in the most significant word.
  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRounds,
    StDone
  } state_e;

  // Word idx (0..7) of the IV.
  function automatic logic [31:0] iv_word(input int unsigned idx);
    return SHA256_IV[(255 - 32 * idx) -: 32];
  endfunction

endpackage

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: latches a block, then strobes the W schedule, the working
// variables and the digest registers through INIT, NUM_ROUNDS rounds and a final update.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               first,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               ready,
  output logic [BLOCK_W-1:0] block_out,
  output logic               w_init,
  output logic               w_next,
  output logic [ROUND_W-1:0] round,
  output logic               h_init,
  output logic               state_init,
  output logic               round_en,
  output logic               h_update,
  output logic               digest_valid
);

  localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS - 1);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic                 first_q, first_d;
  logic                 dvalid_q, dvalid_d;

  // Next-state: abort overrides everything, start only counts in idle.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    block_d  = block_q;
    first_d  = first_q;
    dvalid_d = dvalid_q;
    if (abort) begin
      state_d  = StIdle;
      round_d  = '0;
      dvalid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StInit;
            block_d  = block_in;
            first_d  = first;
            dvalid_d = 1'b0;
            round_d  = '0;
          end
        end
        StInit: begin
          state_d = StRounds;
          round_d = '0;
        end
        StRounds: begin
          if (round_q == LastRound) begin
            state_d = StDone;
            round_d = '0;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
        StDone: begin
          state_d  = StIdle;
          round_d  = '0;
          dvalid_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
          round_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      round_q  <= '0;
      block_q  <= '0;
      first_q  <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      block_q  <= block_d;
      first_q  <= first_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Strobes are pure decodes of the registered state so they never glitch on inputs.
  always_comb begin
    ready      = (state_q == StIdle);
    w_init     = (state_q == StInit);
    state_init = (state_q == StInit);
    h_init     = (state_q == StInit) && first_q;
    round_en   = (state_q == StRounds);
    w_next     = (state_q == StRounds);
    h_update   = (state_q == StDone);
  end

  assign round        = round_q;
  assign block_out    = block_q;
  assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench: stimulus queues expected blocks/digests, a negedge monitor drives a
// behavioural SHA-256 datapath from the DUT strobes and checks every output event.
module tb_sha256_round_ctrl;

  localparam int unsigned NR = 64;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_448 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_M1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset, start, first, abort;
  logic [511:0] block_in;
  logic         ready, w_init, w_next, h_init, state_init, round_en, h_update, digest_valid;
  logic [511:0] block_out;
  logic [5:0]   round;

  sha256_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .first        (first),
    .abort        (abort),
    .block_in     (block_in),
    .ready        (ready),
    .block_out    (block_out),
    .w_init       (w_init),
    .w_next       (w_next),
    .round        (round),
    .h_init       (h_init),
    .state_init   (state_init),
    .round_en     (round_en),
    .h_update     (h_update),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SHA-256 reference functions ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] b);
    logic [31:0]   w [64];
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = b[(511 - 32 * t) -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    end
    for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
    return r;
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k,
                                       input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { logic [511:0] blk; logic fst; int acc; } blk_t;
  typedef struct { logic chk; logic [255:0] dig; } upd_t;

  blk_t blk_q[$];
  upd_t upd_q[$];

  // Monitor plus behavioural datapath, all sampled on the falling edge.
  initial begin
    logic [2047:0] ws;
    logic [255:0]  st, hd;
    logic [511:0]  cur_blk;
    int            cur_acc, exp_round;
    logic          prev_hupd, prev_dv, pend_v;
    upd_t          pend;
    blk_t          e;
    ws = '0; st = '0; hd = '0; cur_blk = '0; cur_acc = 0; exp_round = 0;
    prev_hupd = 1'b0; prev_dv = 1'b0; pend_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hupd = 1'b0;
        prev_dv   = 1'b0;
        pend_v    = 1'b0;
      end else begin
        chk("w_next_eq_round_en", w_next, round_en);
        chk("state_init_eq_w_init", state_init, w_init);
        chk("state_onehot", 512'($countones({ready, w_init, round_en, h_update})), 1);
        if (w_init) begin
          if (blk_q.size() == 0) begin
            chk("unexpected_w_init", 1'b1, 1'b0);
          end else begin
            e = blk_q.pop_front();
            chk("init_block_out", block_out, e.blk);
            chk("init_h_init", h_init, e.fst);
            chk("init_round", round, 0);
            chk("init_cycle", cyc, e.acc + 1);
            chk("init_dvalid", digest_valid, 0);
            cur_blk   = e.blk;
            cur_acc   = e.acc;
            exp_round = 0;
          end
        end
        if (round_en || h_update) chk("block_out_held", block_out, cur_blk);
        if (round_en) begin
          chk("round_index", round, exp_round);
          exp_round++;
        end
        if (h_update) begin
          if (upd_q.size() == 0) begin
            chk("unexpected_h_update", 1'b1, 1'b0);
          end else begin
            pend   = upd_q.pop_front();
            pend_v = 1'b1;
          end
          chk("rounds_per_block", exp_round, NR);
          chk("done_round", round, 0);
          chk("done_cycle", cyc, cur_acc + 2 + NR);
        end
        if (digest_valid && !prev_dv) begin
          chk("dvalid_after_update", prev_hupd, 1);
          chk("ready_with_dvalid", ready, 1);
          if (pend_v && pend.chk) chk("digest", hd, pend.dig);
          pend_v = 1'b0;
        end
        prev_hupd = h_update;
        prev_dv   = digest_valid;
        if (w_init) ws = expand(block_out);
        if (state_init) st = h_init ? IV : hd;
        if (h_init) hd = IV;
        if (round_en) st = rnd(st, K_TAB[round], ws[int'(round)*32 +: 32]);
        if (h_update) hd = add8(hd, st);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic issue(input logic [511:0] blk, input logic fst, output int acc);
    int n = 0;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    chk("issue_ready_timeout", ready, 1);
    start = 1'b1; first = fst; block_in = blk; acc = cyc;
    blk_q.push_back(blk_t'{blk, fst, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dv(input string name);
    int n = 0;
    while (!digest_valid && n < 300) begin @(negedge clk); n++; end
    chk(name, digest_valid, 1);
  endtask

  task automatic wait_round(input logic [5:0] r);
    int n = 0;
    while (!(round_en && round == r) && n < 300) begin @(negedge clk); n++; end
    chk("wait_round_timeout", round, r);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    reset = 1'b1; start = 1'b0; first = 1'b0; abort = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {w_init, w_next, h_init, state_init, round_en, h_update}, 0);
    chk("rst_round", round, 0);
    chk("rst_block_out", block_out, 0);
    chk("rst_dvalid", digest_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);

    // Single "abc" block.
    upd_q.push_back(upd_t'{1'b1, D_ABC});
    issue(BLK_ABC, 1'b1, a1);
    wait_dv("abc_dvalid_timeout");

    // Two-block 448-bit message, second block back-to-back.
    upd_q.push_back(upd_t'{1'b0, '0});
    upd_q.push_back(upd_t'{1'b1, D_448});
    issue(BLK_M1, 1'b1, a1);
    issue(BLK_M2, 1'b0, a2);
    chk("back_to_back_gap", a2 - a1, 3 + NR);
    wait_dv("msg448_dvalid_timeout");

    // Start held through the rounds with a changing block_in.
    while (!ready) @(negedge clk);
    upd_q.push_back(upd_t'{1'b1, D_ABC});
    blk_q.push_back(blk_t'{BLK_ABC, 1'b1, cyc});
    start = 1'b1; first = 1'b1; block_in = BLK_ABC;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      block_in = ~BLK_ABC ^ 512'(i);
      first    = i[0];
    end
    start = 1'b0;
    wait_dv("held_dvalid_timeout");

    // Abort in idle clears digest_valid.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_dvalid", digest_valid, 0);
    chk("idle_abort_ready", ready, 1);

    // Abort at round 30.
    issue(BLK_ABC, 1'b1, a1);
    wait_round(6'd30);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_round", round, 0);
    chk("abort_dvalid", digest_valid, 0);
    chk("abort_h_update", h_update, 0);
    repeat (80) @(negedge clk);
    chk("abort_dvalid_later", digest_valid, 0);

    // Reset at round 40.
    issue(BLK_M1, 1'b0, a1);
    wait_round(6'd40);
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("rst40_strobes", {w_init, w_next, h_init, state_init, round_en, h_update}, 0);
    chk("rst40_round", round, 0);
    chk("rst40_block_out", block_out, 0);
    chk("rst40_dvalid", digest_valid, 0);
    chk("rst40_ready", ready, 1);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Simultaneous start+abort in idle: the start is dropped.
    start = 1'b1; abort = 1'b1; first = 1'b1; block_in = BLK_ABC;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_ready", ready, 1);
    chk("sa_w_init", w_init, 0);
    chk("sa_block_out", block_out, 0);
    repeat (5) @(negedge clk);
    chk("sa_ready_later", ready, 1);

    chk("blk_q_empty", blk_q.size(), 0);
    chk("upd_q_empty", upd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
